// File: rtl/instr_encoder_loader.sv
// Packs RV32I instruction fields into 32-bit words and streams them with byte addresses to an imem loader.
// Optional immediate range checking on out_err is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int CNT_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready; a source holds
  // valid and its payload stable until that edge, and ready may depend on valid.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;
  localparam logic [2:0] FMT_R = 3'b111;

  state_t             state, state_nx;
  logic [2:0]         fmt;
  logic [31:0]        enc;
  logic               imm_bad;
  logic               accept;
  logic [CNT_W-1:0]   remaining;
  logic [ADDR_W-1:0]  addr;

  always_comb begin
    fmt = FMT_R;
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
      7'b0100011:                         fmt = FMT_S;
      7'b1100011:                         fmt = FMT_B;
      7'b1101111:                         fmt = FMT_J;
      7'b0110111, 7'b0010111:             fmt = FMT_U;
      default:                            fmt = FMT_R;
    endcase
  end

  always_comb begin
    enc = {funct7, rs2, rs1, funct3, rd, op};
    case (fmt)
      FMT_I: enc = {imm[11:0], rs1, funct3, rd, op};
      FMT_S: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
      FMT_B: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
      FMT_J: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      FMT_U: enc = {imm[31:12], rd, op};
      default: enc = {funct7, rs2, rs1, funct3, rd, op};
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Flags immediates that the chosen format cannot represent; the truncated word still goes out.
  always_comb begin
    imm_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: imm_bad = (imm[31:11] != {21{imm[11]}});
      FMT_B:        imm_bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
      FMT_J:        imm_bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
      FMT_U:        imm_bad = (imm[11:0] != 12'd0);
      default:      imm_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) out_err <= 1'b0;
    else if (accept) out_err <= imm_bad;
  end
`else
  logic unused_imm_lsb;
  assign imm_bad        = 1'b0;
  assign unused_imm_lsb = imm[0] | imm_bad;
  assign out_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = (count == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        // Single output register: refill in the same cycle it drains.
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && remaining == CNT_W'(1)) state_nx = S_FLUSH;
      end
      S_FLUSH: begin
        if (out_valid && out_ready) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      addr      <= ADDR_W'(BASE_ADDR);
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_addr  <= ADDR_W'(BASE_ADDR);
    end else begin
      if (state == S_IDLE && start) begin
        remaining <= count;
        addr      <= ADDR_W'(BASE_ADDR);
      end
      if (accept) begin
        out_instr <= enc;
        out_addr  <= addr;
        addr      <= addr + ADDR_W'(4);
        remaining <= remaining - CNT_W'(1);
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: known-encoding table, randomized jobs against a
// field-arithmetic reference model, backpressure, zero-count, address wrap and mid-job reset.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 10;
  localparam int W      = 32 + ADDR_W + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, start, in_valid, in_ready, out_valid, out_ready, out_err, done;
  logic [CNT_W-1:0]  count;
  logic [6:0]        op, funct7;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [31:0]       imm, out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic [1:0]        dbg_state;

  logic              reset2, start2, in_valid2, in_ready2, out_valid2, out_ready2, out_err2, done2;
  logic [CNT_W-1:0]  count2;
  logic [31:0]       out_instr2;
  logic [3:0]        out_addr2;
  logic [1:0]        dbg_state2;

  instr_encoder_loader dut (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .done(done), .dbg_state(dbg_state)
  );

  instr_encoder_loader #(.ADDR_W(4), .BASE_ADDR(12), .CNT_W(CNT_W)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .count(count2),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2), .out_addr(out_addr2),
    .out_err(out_err2), .done(done2), .dbg_state(dbg_state2)
  );

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } fld_t;

  typedef struct {
    fld_t        f;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

`ifdef IMM_RANGE_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  fld_t         src_q[$];
  logic [31:0]  last_instr;
  logic         last_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: place each immediate slice by shift/mask arithmetic; range by signed bounds.
  function automatic logic [32:0] model(input fld_t f);
    longint s;
    bit [31:0] i, w, base_r;
    bit e;
    s = longint'($signed(f.imm));
    i = f.imm;
    e = 1'b0;
    base_r = 32'(f.op) | (32'(f.rd) << 7) | (32'(f.f3) << 12) | (32'(f.rs1) << 15) | (32'(f.rs2) << 20);
    case (f.op)
      7'h13, 7'h03, 7'h67: begin
        w = 32'(f.op) | (32'(f.rd) << 7) | (32'(f.f3) << 12) | (32'(f.rs1) << 15) | ((i & 32'hfff) << 20);
        e = (s < -2048) || (s > 2047);
      end
      7'h23: begin
        w = 32'(f.op) | ((i & 31) << 7) | (32'(f.f3) << 12) | (32'(f.rs1) << 15) | (32'(f.rs2) << 20)
          | (((i >> 5) & 127) << 25);
        e = (s < -2048) || (s > 2047);
      end
      7'h63: begin
        w = 32'(f.op) | (((i >> 11) & 1) << 7) | (((i >> 1) & 15) << 8) | (32'(f.f3) << 12)
          | (32'(f.rs1) << 15) | (32'(f.rs2) << 20) | (((i >> 5) & 63) << 25) | (((i >> 12) & 1) << 31);
        e = (s < -4096) || (s > 4095) || (i % 2 != 0);
      end
      7'h6f: begin
        w = 32'(f.op) | (32'(f.rd) << 7) | (((i >> 12) & 255) << 12) | (((i >> 11) & 1) << 20)
          | (((i >> 1) & 1023) << 21) | (((i >> 20) & 1) << 31);
        e = (s < -(64'sd1 << 20)) || (s >= (64'sd1 << 20)) || (i % 2 != 0);
      end
      7'h37, 7'h17: begin
        w = 32'(f.op) | (32'(f.rd) << 7) | (i & 32'hfffff000);
        e = (i % 4096) != 0;
      end
      default: w = base_r | (32'(f.f7) << 25);
    endcase
    if (!ERR_ON) e = 1'b0;
    return {e, w};
  endfunction

  function automatic fld_t next_field();
    fld_t f;
    if (src_q.size() != 0) return src_q.pop_front();
    case ($urandom_range(0, 9))
      0: f.op = 7'h13;  1: f.op = 7'h03;  2: f.op = 7'h67;  3: f.op = 7'h23;  4: f.op = 7'h63;
      5: f.op = 7'h6f;  6: f.op = 7'h37;  7: f.op = 7'h17;  8: f.op = 7'h33;
      default: f.op = 7'($urandom);
    endcase
    f.rd = 5'($urandom); f.rs1 = 5'($urandom); f.rs2 = 5'($urandom);
    f.f3 = 3'($urandom); f.f7 = 7'($urandom);
    case ($urandom_range(0, 3))
      0: f.imm = $urandom;
      1: f.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      2: f.imm = (32'($urandom_range(0, 32'h1fffff)) - 32'h100000) & ~32'd1;
      default: f.imm = $urandom & 32'hfffff000;
    endcase
    return f;
  endfunction

  task automatic drive_fields(input fld_t f);
    op = f.op; rd = f.rd; rs1 = f.rs1; rs2 = f.rs2; funct3 = f.f3; funct7 = f.f7; imm = f.imm;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low for 3 cycles once a word is waiting
  task automatic run_job(input int n, input int mode);
    int sent, got, cyc, stall;
    bit finished, pending, hold_chk;
    fld_t cur;
    logic [32:0] r;
    logic [W-1:0] held, exp_w;
    sent = 0; got = 0; cyc = 0; stall = 0;
    finished = 0; pending = 0; hold_chk = 0;
    exp_q.delete();
    @(negedge clk);
    start = 1'b1; count = CNT_W'(n); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    cur = next_field();
    while (!finished && cyc < 3000) begin
      in_valid = pending || (sent < n && $urandom_range(0, 3) != 0);
      drive_fields(cur);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (out_valid && stall < 3) begin out_ready = 1'b0; stall++; end
          else out_ready = 1'b1;
        end
      endcase
      start = ($urandom_range(0, 7) == 0);
      count = CNT_W'($urandom);
      #1;
      if (hold_chk) check("stall_stable", {out_valid, out_instr, out_addr, out_err}, {1'b1, held});
      hold_chk = 0;
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        held = {out_instr, out_addr, out_err};
        hold_chk = 1;
      end
      if (done) begin
        check("done_after_drain", {32'(sent), 32'(got)}, {32'(n), 32'(n)});
        finished = 1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", 1, 0);
        else begin
          exp_w = exp_q.pop_front();
          check("word", {out_instr, out_addr, out_err}, exp_w);
        end
        last_instr = out_instr; last_err = out_err;
        got++;
      end
      if (in_valid && in_ready) begin
        r = model(cur);
        exp_q.push_back({r[31:0], ADDR_W'(sent * 4), r[32]});
        sent++;
        pending = 0;
        cur = next_field();
      end else begin
        pending = in_valid;
      end
      @(negedge clk);
      cyc++;
    end
    if (!finished) check("job_timeout", 1, 0);
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("idle_quiet", {done, in_ready, out_valid, dbg_state}, 5'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("words_emitted", got, n);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{'{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5},          32'h00500093, 1'b0};
    tbl[1] = '{'{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8},          32'h0020A423, 1'b0};
    tbl[2] = '{'{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC},   32'hFE000EE3, 1'b0};
    tbl[3] = '{'{7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8},          32'h008000EF, 1'b0};
    tbl[4] = '{'{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000},   32'h123452B7, 1'b0};
    tbl[5] = '{'{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF},  32'h002081B3, 1'b0};
    tbl[6] = '{'{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0},         32'h402081B3, 1'b0};
    tbl[7] = '{'{7'h17, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000},  32'h00001517, 1'b0};
    tbl[8] = '{'{7'h03, 5'd6, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFF},   32'hFFF12303, 1'b0};
    tbl[9] = '{'{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800},   32'h80000093, ERR_ON};

    reset = 1'b1; reset2 = 1'b1; start = 1'b0; start2 = 1'b0; count = '0; count2 = '0;
    in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
    drive_fields(tbl[0].f);
    repeat (3) @(negedge clk);
    reset = 1'b0; reset2 = 1'b0;
    #1;
    check("reset_ctrl", {in_ready, out_valid, out_err, done, dbg_state}, 6'd0);
    check("reset_data", {out_instr, out_addr}, {32'd0, 10'd0});
    check("reset_addr2", {out_valid2, out_addr2}, {1'b0, 4'hC});

    for (int t = 0; t < 10; t++) begin
      src_q.push_back(tbl[t].f);
      run_job(1, 0);
      check($sformatf("tbl%0d_instr", t), last_instr, tbl[t].exp_instr);
      check($sformatf("tbl%0d_err", t), last_err, tbl[t].exp_err);
    end

    run_job(3, 2);
    run_job(0, 0);
    for (int j = 0; j < 8; j++) run_job($urandom_range(1, 24), 1);

    // Narrow address space: second word wraps from 0xC to 0x0.
    @(negedge clk);
    start2 = 1'b1; count2 = CNT_W'(2); out_ready2 = 1'b1; in_valid2 = 1'b0;
    @(negedge clk);
    start2 = 1'b0; in_valid2 = 1'b1; drive_fields(tbl[0].f);
    #1 check("wrap_in_ready", in_ready2, 1);
    @(negedge clk);
    drive_fields(tbl[3].f);
    #1 check("wrap_w0", {out_valid2, out_instr2, out_addr2}, {1'b1, 32'h00500093, 4'hC});
    @(negedge clk);
    in_valid2 = 1'b0;
    #1 check("wrap_w1", {out_valid2, out_instr2, out_addr2}, {1'b1, 32'h008000EF, 4'h0});
    @(negedge clk);
    #1 check("wrap_done", done2, 1);
    @(negedge clk);
    #1 check("wrap_done_once", {done2, dbg_state2}, 3'd0);

    // Reset while a word is stalled: word dropped, back to idle, no done.
    @(negedge clk);
    start2 = 1'b1; count2 = CNT_W'(5);
    @(negedge clk);
    start2 = 1'b0; in_valid2 = 1'b1; out_ready2 = 1'b0;
    @(negedge clk);
    in_valid2 = 1'b0;
    #1 check("midjob_pending", out_valid2, 1);
    reset2 = 1'b1;
    @(negedge clk);
    reset2 = 1'b0; out_ready2 = 1'b1;
    #1 check("midjob_reset", {out_valid2, in_ready2, dbg_state2, out_addr2}, {1'b0, 1'b0, 2'd0, 4'hC});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1 check("midjob_no_done", {done2, out_valid2}, 2'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
